// File: rtl/serial_byte_capture_ctrl_if.sv
// rtl/serial_byte_capture_ctrl_if.sv - serial frame source / byte consumer bundle for serial_byte_capture_ctrl
interface serial_byte_capture_ctrl_if;
    logic       start;
    logic       serial_in;
    logic       byte_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    modport master (
        output start, serial_in, byte_ready,
        input  byte_out, byte_valid, busy, overrun, parity_err
    );

    modport slave (
        input  start, serial_in, byte_ready,
        output byte_out, byte_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/serial_byte_capture_ctrl.sv
// rtl/serial_byte_capture_ctrl.sv - MSB-first serial byte capture with one-entry output holding register
// Optional feature: PARITY_CHECK_EN adds a 9th even-parity bit check.
module serial_byte_capture_ctrl #(
    parameter int BIT_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_byte_capture_ctrl_if.slave   bus
);
    localparam int DIV_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef PARITY_CHECK_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [7:0]       sh;
    logic [3:0]       bit_cnt;
    logic [DIV_W-1:0] div;
    logic [7:0]       byte_out_r;
    logic             byte_valid_r;
    logic             overrun_r;
    logic             parity_err_r;

    logic             tick;
    logic             last_data_tick;
    logic             complete;
    logic             par_fail;
    logic [7:0]       assembled;

    assign tick           = (state != IDLE) && (div == DIV_LAST);
    assign last_data_tick = (state == SHIFT) && tick && (bit_cnt == 4'd7);

`ifdef PARITY_CHECK_EN
    // Even parity: data ones plus the parity bit must total an even count.
    logic par_tick;
    assign par_tick  = (state == PARITY) && tick;
    assign complete  = par_tick && !(^sh ^ bus.serial_in);
    assign par_fail  = par_tick &&  (^sh ^ bus.serial_in);
    assign assembled = sh;
`else
    assign complete  = last_data_tick;
    assign par_fail  = 1'b0;
    assign assembled = {sh[6:0], bus.serial_in};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (last_data_tick) begin
`ifdef PARITY_CHECK_EN
                    next_state = PARITY;
`else
                    next_state = IDLE;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (tick) begin
                    next_state = IDLE;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh           <= 8'd0;
            bit_cnt      <= 4'd0;
            div          <= '0;
            byte_out_r   <= 8'd0;
            byte_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= par_fail;
            if (state == IDLE) begin
                if (bus.start) begin
                    bit_cnt <= 4'd0;
                    div     <= '0;
                end
            end else begin
                div <= tick ? '0 : div + 1'b1;
                if (tick && state == SHIFT) begin
                    sh      <= {sh[6:0], bus.serial_in};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end

            // A completion may land on the same edge the consumer drains the old byte.
            if (complete) begin
                if (!byte_valid_r || bus.byte_ready) begin
                    byte_out_r   <= assembled;
                    byte_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (byte_valid_r && bus.byte_ready) begin
                byte_valid_r <= 1'b0;
            end
        end
    end

    assign bus.byte_out   = byte_out_r;
    assign bus.byte_valid = byte_valid_r;
    assign bus.busy       = (state != IDLE);
    assign bus.overrun    = overrun_r;
    assign bus.parity_err = parity_err_r;
endmodule

// File: tb/tb_serial_byte_capture_ctrl.sv
// tb/tb_serial_byte_capture_ctrl.sv - scoreboard bench for serial_byte_capture_ctrl at BIT_CYCLES 1 and 4
module tb_serial_byte_capture_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       pv[2];
    logic       pr[2];

    always #5 clk = ~clk;

    serial_byte_capture_ctrl_if ia();
    serial_byte_capture_ctrl_if ib();

    serial_byte_capture_ctrl #(.BIT_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    serial_byte_capture_ctrl #(.BIT_CYCLES(4)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic s, input logic d, input logic r);
        if (sel == 0) begin
            ia.start = s; ia.serial_in = d; ia.byte_ready = r;
        end else begin
            ib.start = s; ib.serial_in = d; ib.byte_ready = r;
        end
    endtask

    function automatic logic [7:0] f_byte(input int sel);
        return (sel == 0) ? ia.byte_out : ib.byte_out;
    endfunction

    // {byte_valid, busy, overrun, parity_err}
    function automatic logic [3:0] f_flags(input int sel);
        if (sel == 0) return {ia.byte_valid, ia.busy, ia.overrun, ia.parity_err};
        return {ib.byte_valid, ib.busy, ib.overrun, ib.parity_err};
    endfunction

    // Scoreboard monitor: a byte is newly presented when valid rises or follows a handshake.
    task automatic mon(input int sel);
        logic       v;
        logic       r;
        logic [7:0] b;
        logic [7:0] e;
        v = (sel == 0) ? ia.byte_valid : ib.byte_valid;
        r = (sel == 0) ? ia.byte_ready : ib.byte_ready;
        b = f_byte(sel);
        if (v && (!pv[sel] || pr[sel])) begin
            if ((sel == 0 && qa.size() == 0) || (sel == 1 && qb.size() == 0)) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected[%0d] actual=%0h expected=none", sel, b);
            end else begin
                e = (sel == 0) ? qa.pop_front() : qb.pop_front();
                chk($sformatf("sb_byte[%0d]", sel), 32'(b), 32'(e));
            end
        end
        pv[sel] = v;
        pr[sel] = r;
    endtask

    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0; pr[0] = 1'b0; pr[1] = 1'b0;
        forever begin
            @(negedge clk);
            mon(0);
            mon(1);
        end
    end

    task automatic frame(input int sel, input logic [7:0] d, input bit rdy_last,
                         input bit glitch, input bit bad_par, input bit push);
        logic [8:0] v;
        int         n;
        int         bc;
        logic       b;
        bc = (sel == 0) ? 1 : 4;
`ifdef PARITY_CHECK_EN
        v = {d, (^d) ^ bad_par};
        n = 9;
`else
        v = {d, 1'b0};
        n = 8;
`endif
        drive(sel, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk($sformatf("busy_start[%0d]", sel), 32'(f_flags(sel)[2]), 32'd1);
        for (int i = 0; i < n; i++) begin
            b = v[8 - i];
            for (int c = 0; c < bc; c++) begin
                // Inverted data between sample edges must be ignored.
                drive(sel, glitch && (i == 2 || i == 5) && c == 0,
                      (c == bc - 1) ? b : ~b,
                      rdy_last && (i == n - 1) && (c == bc - 1));
                if (i == n - 1 && c == bc - 1)
                    chk($sformatf("busy_last[%0d]", sel), 32'(f_flags(sel)[2]), 32'd1);
                tick(1);
            end
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
        if (push && !bad_par) begin
            if (sel == 0) qa.push_back(d);
            else          qb.push_back(d);
        end
        chk($sformatf("busy_done[%0d]", sel), 32'(f_flags(sel)[2]), 32'd0);
    endtask

    task automatic accept(input int sel);
        drive(sel, 1'b0, 1'b0, 1'b1);
        tick(1);
        drive(sel, 1'b0, 1'b0, 1'b0);
        chk($sformatf("accept_valid[%0d]", sel), 32'(f_flags(sel)[3]), 32'd0);
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b0, k[0], 1'b0);
            drive(1, 1'b0, ~k[0], 1'b0);
            tick(1);
        end
        chk("rst_byte_a", 32'(f_byte(0)), 32'h00);
        chk("rst_flags_a", 32'(f_flags(0)), 32'h0);
        chk("rst_byte_b", 32'(f_byte(1)), 32'h00);
        chk("rst_flags_b", 32'(f_flags(1)), 32'h0);

        // Basic frame
        frame(0, 8'hA5, 0, 0, 0, 1);
        chk("basic_byte", 32'(f_byte(0)), 32'hA5);
        chk("basic_flags", 32'(f_flags(0)), 32'b1000);
        accept(0);

        // Overrun, back-to-back starts at the earliest legal edge
        frame(0, 8'h11, 0, 0, 0, 1);
        frame(0, 8'h22, 0, 0, 0, 0);
        chk("ovr_byte", 32'(f_byte(0)), 32'h11);
        chk("ovr_flags", 32'(f_flags(0)), 32'b1010);
        tick(3);
        chk("ovr_sticky", 32'(f_flags(0)), 32'b1010);
        accept(0);
        chk("ovr_after_accept", 32'(f_flags(0)), 32'b0010);
        chk("ovr_byte_held", 32'(f_byte(0)), 32'h11);

        // Simultaneous accept and completion
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_clear_ovr", 32'(f_flags(0)), 32'h0);
        frame(0, 8'h11, 0, 0, 0, 1);
        frame(0, 8'h22, 1, 0, 0, 1);
        chk("simul_byte", 32'(f_byte(0)), 32'h22);
        chk("simul_flags", 32'(f_flags(0)), 32'b1000);
        accept(0);

        // Start pulses mid-frame are ignored; reset mid-frame discards the frame
        frame(0, 8'h96, 0, 1, 0, 1);
        chk("glitch_byte", 32'(f_byte(0)), 32'h96);
        drive(0, 1'b1, 1'b0, 1'b0);
        tick(1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b0, 1'b1, 1'b0);
            tick(1);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_flags", 32'(f_flags(0)), 32'h0);
        chk("midrst_byte", 32'(f_byte(0)), 32'h00);
        frame(0, 8'hF0, 0, 0, 0, 1);
        chk("post_rst_byte", 32'(f_byte(0)), 32'hF0);
        accept(0);

`ifdef PARITY_CHECK_EN
        frame(0, 8'h01, 0, 0, 1, 1);
        chk("par_err_pulse", 32'(f_flags(0)), 32'b0001);
        tick(1);
        chk("par_err_clear", 32'(f_flags(0)), 32'b0000);
`endif

        // Divided rate
        frame(1, 8'h3C, 0, 0, 0, 1);
        chk("div_byte", 32'(f_byte(1)), 32'h3C);
        chk("div_flags", 32'(f_flags(1)), 32'b1000);
        accept(1);
        tick(2);

        chk("sb_drain_a", 32'(qa.size()), 32'd0);
        chk("sb_drain_b", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_byte_capture_ctrl.md
# serial_byte_capture_ctrl

Frame-sequencing controller for the team's 8-bit serial-in shift datapath. It owns an 8-bit shift register, gates shifting to exactly eight bit periods per frame after a start pulse, and transfers the completed byte into a one-entry output holding register. The consumer drains that register with a valid/ready handshake. The block sits between a serial source (bit line plus frame start) and a byte-wide consumer.

## Interface
- BIT_CYCLES, default 1: clocks per bit period; legal range 1..256.
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  frame start pulse; honoured only in IDLE.
- serial_in  input  1  serial data bit, MSB first.
- byte_ready  input  1  consumer accepts byte_out this cycle.
- byte_out  output  8  last completed byte.
- byte_valid  output  1  byte_out holds an unconsumed byte.
- busy  output  1  frame in progress (state is not IDLE).
- overrun  output  1  sticky: a completed byte was dropped because the holding register was full.
- parity_err  output  1  one-cycle pulse when a frame fails its parity check.

## Operation
- States:
  - IDLE: waits for start; start=1 -> SHIFT, bit counter=0, divider=0.
  - SHIFT: divider counts 0..BIT_CYCLES-1. At terminal count, serial_in is sampled: sh <= {sh[6:0], serial_in}, bit counter +1. After the 8th sample -> IDLE, or -> PARITY if PARITY_CHECK_EN is defined.
  - PARITY: one more bit period; samples the parity bit, then -> IDLE.
- Shift register shifts only on sample ticks; it holds otherwise.
- Frame completion, i.e. the last sample tick:
  - If byte_valid=0, or byte_valid=1 with byte_ready=1 in the same cycle: byte_out <= assembled byte, byte_valid <= 1.
  - If byte_valid=1 and byte_ready=0: the new byte is discarded, byte_out is unchanged, overrun <= 1.
- Handshake: byte_valid & byte_ready with no completion in the same cycle -> byte_valid <= 0 next edge. byte_out is held until it is replaced.
- start while busy=1 is ignored; it is neither queued nor allowed to restart the frame.
- serial_in is ignored outside sample ticks.
- overrun clears only on rst.
- Bit counter is 4 bits; divider width is clog2(BIT_CYCLES), minimum 1. No wrap occurs within a frame.
- rst (including mid-frame) forces the following on the next edge:
  - state IDLE; shift register, counters and byte_out all 0;
  - byte_valid, busy, overrun and parity_err all 0.
  - The partial frame is discarded.

## Timing
- Reset values: byte_out=8'd0, byte_valid=0, busy=0, overrun=0, parity_err=0.
- start is sampled at edge E0, and busy=1 after E0.
- Bit i (i=0 is MSB) is sampled at edge E0+(i+1)*BIT_CYCLES.
- Without parity:
  - byte_valid rises and busy falls after edge E0+8*BIT_CYCLES.
  - A new start is honoured no earlier than edge E0+8*BIT_CYCLES+1.
- With parity: completion and busy fall move to E0+9*BIT_CYCLES.
- Frame length, start to byte_valid: 8*BIT_CYCLES clocks, or 9*BIT_CYCLES with parity.
- byte_ready is combinationally independent; there are no combinational paths from inputs to outputs.
- parity_err is high for exactly one cycle, after the completion edge.

## Configuration
- PARITY_CHECK_EN defined:
  - The PARITY state is present; the 9th bit is checked as even parity over the 8 data bits plus the parity bit.
  - Mismatch: byte discarded, byte_valid and overrun unaffected, parity_err pulses 1 cycle.
  - Match: normal completion rules apply.
- PARITY_CHECK_EN undefined: no PARITY state, frames are 8 bits, and parity_err is tied to 0.

## Test plan
- Reset then idle:
  - rst=1 for 2 cycles, then serial_in toggling with start=0 -> all outputs 0, busy stays 0.
- Basic frame:
  - BIT_CYCLES=1; start at E0, serial_in MSB-first 1,0,1,0,0,1,0,1 on E1..E8 -> byte_out=8'hA5 and byte_valid=1 after E8.
  - byte_ready=1 one cycle later -> byte_valid=0.
- Divided rate:
  - BIT_CYCLES=4, byte 8'h3C -> sampling only at E4, E8, …, E32; byte_valid after E32.
  - Changing serial_in between sample edges has no effect.
- Overrun:
  - Frame 8'h11 completes and is not accepted; frame 8'h22 completes -> byte_out stays 8'h11, overrun=1 and remains set.
  - Accepting 8'h11 clears byte_valid only.
- Simultaneous accept and completion:
  - byte_ready=1 on the completion edge of 8'h22 while 8'h11 is held -> byte_out=8'h22, byte_valid stays 1, overrun=0.
- Reset mid-frame and start while busy:
  - start pulses at bits 2 and 5 of a frame -> ignored.
  - rst at bit 4 -> busy=0 and byte_valid=0 next edge.
  - The following full frame 8'hF0 is captured correctly.
  - With PARITY_CHECK_EN: data 8'h01 with parity bit 0 -> parity_err pulse, no byte_valid.
